// File: rtl/pll_mdrp_pkg.sv
// Shared constants for the PLLA MD-port controller: MD opcodes, host command
// encodings and FSM state codes.
package pll_mdrp_pkg;

  // MD port opcodes, sampled by the PLL on the MDCLK rise
  localparam logic [1:0] MD_NOP = 2'b00;
  localparam logic [1:0] MD_WR  = 2'b01;
  localparam logic [1:0] MD_RD  = 2'b10;
  localparam logic [1:0] MD_LDA = 2'b11;

  // Host command encodings; the reserved code behaves as a commit
  localparam logic [1:0] OP_WRITE  = 2'd0;
  localparam logic [1:0] OP_READ   = 2'd1;
  localparam logic [1:0] OP_COMMIT = 2'd2;
  localparam logic [1:0] OP_RSVD   = 2'd3;

  typedef logic [3:0] state_t;

  localparam state_t ST_IDLE  = 4'd0;
  localparam state_t ST_A_LO  = 4'd1;
  localparam state_t ST_A_HI  = 4'd2;
  localparam state_t ST_D_LO  = 4'd3;
  localparam state_t ST_D_HI  = 4'd4;
  localparam state_t ST_CAP   = 4'd5;
  localparam state_t ST_PRST  = 4'd6;
  localparam state_t ST_WLOCK = 4'd7;
  localparam state_t ST_RESP  = 4'd8;

  // A load-address phase is skipped only when tracking is on and the PLL's
  // internal address pointer is known to already equal the target.
  function automatic logic addr_needed(input logic       track_en,
                                       input logic       trk_valid,
                                       input logic [7:0] target,
                                       input logic [7:0] trk_addr);
    return !track_en || !trk_valid || (target != trk_addr);
  endfunction

endpackage

// File: rtl/pll_mdrp_ctrl_sync2.sv
// Multi-stage flop synchronizer for a single asynchronous level input,
// asynchronously cleared to 0.
module sync2 #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff_reg;

  generate
    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
      if (gi == 0) begin : g_first
        always_ff @(posedge clk or negedge reset_n) begin
          if (!reset_n) ff_reg[gi] <= 1'b0;
          else          ff_reg[gi] <= d;
        end
      end else begin : g_rest
        always_ff @(posedge clk or negedge reset_n) begin
          if (!reset_n) ff_reg[gi] <= 1'b0;
          else          ff_reg[gi] <= ff_reg[gi-1];
        end
      end
    end
  endgenerate

  assign q = ff_reg[STAGES-1];

endmodule

// File: rtl/pll_mdrp_ctrl.sv
// PLLA MD-port initiator: turns host write/read/commit commands into two-cycle
// MDCLK phases, captures read data and re-locks the PLL after a commit.
module pll_mdrp_ctrl
  import pll_mdrp_pkg::*;
#(
  parameter int RST_CYCLES   = 16,
  parameter int LOCK_TIMEOUT = 1048575,
  parameter int ADDR_TRACK   = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_addr,
  input  logic [7:0] cmd_data,
  input  logic       cmd_inc,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       rsp_err,
  output logic       mdclk,
  output logic [1:0] mdopc,
  output logic       mdainc,
  output logic [7:0] mdwdi,
  input  logic [7:0] mdrdo,
  output logic       pll_reset,
  input  logic       pll_lock,
  output logic       locked
);

  localparam logic [19:0] RST_LAST = 20'(RST_CYCLES - 1);
  localparam logic [19:0] TMO_LAST = 20'(LOCK_TIMEOUT - 1);

  state_t      state_reg, state_next;
  logic        rd_reg;
  logic [7:0]  addr_reg;
  logic [7:0]  data_reg;
  logic        inc_reg;
  logic [7:0]  trk_addr_reg;
  logic        trk_valid_reg;
  logic [19:0] cnt_reg;
  logic [7:0]  rsp_data_reg;
  logic        rsp_err_reg;

  logic cmd_is_rw;
  logic need_addr;
  logic in_a;
  logic in_d;

  sync2 #(.STAGES(2)) u_lock_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (pll_lock),
    .q       (locked)
  );

  assign cmd_is_rw = (cmd_op == OP_WRITE) || (cmd_op == OP_READ);
  assign need_addr = addr_needed(ADDR_TRACK != 0, trk_valid_reg, cmd_addr, trk_addr_reg);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (cmd_valid) begin
          if (cmd_is_rw) state_next = need_addr ? ST_A_LO : ST_D_LO;
          else           state_next = ST_PRST;
        end
      end
      ST_A_LO:  state_next = ST_A_HI;
      ST_A_HI:  state_next = ST_D_LO;
      ST_D_LO:  state_next = ST_D_HI;
      ST_D_HI:  state_next = rd_reg ? ST_CAP : ST_RESP;
      ST_CAP:   state_next = ST_RESP;
      ST_PRST:  if (cnt_reg == RST_LAST) state_next = ST_WLOCK;
      // Lock wins over a coincident timeout
      ST_WLOCK: if (locked || cnt_reg == TMO_LAST) state_next = ST_RESP;
      ST_RESP:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= ST_IDLE;
      rd_reg        <= 1'b0;
      addr_reg      <= 8'h00;
      data_reg      <= 8'h00;
      inc_reg       <= 1'b0;
      trk_addr_reg  <= 8'h00;
      trk_valid_reg <= 1'b0;
      cnt_reg       <= 20'd0;
      rsp_data_reg  <= 8'h00;
      rsp_err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        ST_IDLE: begin
          if (cmd_valid) begin
            rd_reg      <= (cmd_op == OP_READ);
            addr_reg    <= cmd_addr;
            data_reg    <= cmd_data;
            inc_reg     <= cmd_inc;
            rsp_err_reg <= 1'b0;
            cnt_reg     <= 20'd0;
          end
        end
        ST_A_HI: begin
          trk_addr_reg  <= addr_reg;
          trk_valid_reg <= 1'b1;
        end
        ST_D_HI: begin
          // The PLL post-increments its pointer when MDAINC is sampled high
          if (inc_reg) trk_addr_reg <= trk_addr_reg + 8'd1;
        end
        ST_CAP: rsp_data_reg <= mdrdo;
        ST_PRST: begin
          trk_valid_reg <= 1'b0;
          cnt_reg       <= (cnt_reg == RST_LAST) ? 20'd0 : cnt_reg + 20'd1;
        end
        ST_WLOCK: begin
          cnt_reg <= cnt_reg + 20'd1;
          if (!locked && cnt_reg == TMO_LAST) rsp_err_reg <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign in_a = (state_reg == ST_A_LO) || (state_reg == ST_A_HI);
  assign in_d = (state_reg == ST_D_LO) || (state_reg == ST_D_HI);

  // Outputs decode straight from state so an async reset idles them at once
  assign cmd_ready = (state_reg == ST_IDLE);
  assign rsp_valid = (state_reg == ST_RESP);
  assign rsp_data  = rsp_data_reg;
  assign rsp_err   = rsp_err_reg;
  assign pll_reset = (state_reg == ST_PRST);
  assign mdclk     = (state_reg == ST_A_HI) || (state_reg == ST_D_HI);
  assign mdainc    = in_d && inc_reg;
  assign mdopc     = in_a ? MD_LDA : (in_d ? (rd_reg ? MD_RD : MD_WR) : MD_NOP);
  assign mdwdi     = in_a ? addr_reg : ((in_d && !rd_reg) ? data_reg : 8'h00);

endmodule

// File: tb/tb_pll_mdrp_ctrl.sv
// Scoreboard bench for pll_mdrp_ctrl with a behavioural MD register file and
// a PLL lock model.
module tb_pll_mdrp_ctrl;

  typedef struct {
    logic       chk_data;
    logic [7:0] data;
    logic       err;
    int         lat;
    int         naddr;
    logic       is_commit;
    int         acc;
    int         naddr0;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_addr;
  logic [7:0] cmd_data;
  logic       cmd_inc;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       rsp_err;
  logic       mdclk;
  logic [1:0] mdopc;
  logic       mdainc;
  logic [7:0] mdwdi;
  logic [7:0] mdrdo = 8'h00;
  logic       pll_reset;
  logic       pll_lock = 1'b0;
  logic       locked;

  logic       cmd_valid_b;
  logic       cmd_ready_b;
  logic       rsp_valid_b;
  logic [7:0] rsp_data_b;
  logic       rsp_err_b;
  logic       mdclk_b;
  logic [1:0] mdopc_b;
  logic       mdainc_b;
  logic [7:0] mdwdi_b;
  logic       pll_reset_b;
  logic       locked_b;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int naddr_cnt = 0;
  int rst_run  = 0;
  int last_rst = 0;
  int lk_cnt   = 0;
  int ahi_b    = 0;
  logic lock_stuck = 1'b0;
  logic [7:0] md_addr = 8'h00;
  logic [7:0] md_mem [256];
  exp_t expq[$];
  exp_t mon_e;

  pll_mdrp_ctrl #(.RST_CYCLES(16), .LOCK_TIMEOUT(100), .ADDR_TRACK(1)) dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_inc(cmd_inc),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .mdclk(mdclk), .mdopc(mdopc), .mdainc(mdainc), .mdwdi(mdwdi), .mdrdo(mdrdo),
    .pll_reset(pll_reset), .pll_lock(pll_lock), .locked(locked)
  );

  pll_mdrp_ctrl #(.RST_CYCLES(16), .LOCK_TIMEOUT(100), .ADDR_TRACK(0)) dut_nt (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid_b), .cmd_ready(cmd_ready_b),
    .cmd_op(2'd0), .cmd_addr(8'h12), .cmd_data(8'h5A), .cmd_inc(1'b0),
    .rsp_valid(rsp_valid_b), .rsp_data(rsp_data_b), .rsp_err(rsp_err_b),
    .mdclk(mdclk_b), .mdopc(mdopc_b), .mdainc(mdainc_b), .mdwdi(mdwdi_b), .mdrdo(8'h00),
    .pll_reset(pll_reset_b), .pll_lock(pll_lock), .locked(locked_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // MD register file: opcode/data are stable across the phase, act on the rise
  always @(posedge mdclk) begin
    case (mdopc)
      2'b11: begin md_addr = mdwdi; naddr_cnt++; end
      2'b01: begin md_mem[md_addr] = mdwdi; if (mdainc) md_addr = md_addr + 8'd1; end
      2'b10: begin mdrdo <= md_mem[md_addr]; if (mdainc) md_addr = md_addr + 8'd1; end
      default: ;
    endcase
  end

  // Lock rises 5 cycles after reset release unless stuck
  always @(posedge clk) begin
    if (pll_reset) begin
      lk_cnt   <= 0;
      pll_lock <= 1'b0;
    end else begin
      if (lk_cnt < 1000) lk_cnt <= lk_cnt + 1;
      pll_lock <= !lock_stuck && (lk_cnt + 1 >= 5);
    end
  end

  always @(negedge clk) begin
    if (pll_reset) rst_run++;
    else if (rst_run != 0) begin
      last_rst = rst_run;
      rst_run  = 0;
    end
    if (mdclk_b && mdopc_b == 2'b11) ahi_b++;
  end

  // Scoreboard monitor
  always @(negedge clk) begin
    if (reset_n && rsp_valid) begin
      if (expq.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_rsp: got rsp_valid with empty queue (cycle %0d)", cyc);
      end else begin
        mon_e = expq.pop_front();
        check("rsp_latency", cyc - mon_e.acc, mon_e.lat);
        check("rsp_err", {31'd0, rsp_err}, {31'd0, mon_e.err});
        check("addr_phases", naddr_cnt - mon_e.naddr0, mon_e.naddr);
        if (mon_e.chk_data) check("rsp_data", {24'd0, rsp_data}, {24'd0, mon_e.data});
        if (mon_e.is_commit) check("pll_reset_len", last_rst, 16);
        $display("rsp: acc=%0d lat=%0d err=%0b data=%02h", mon_e.acc, cyc - mon_e.acc, rsp_err, rsp_data);
      end
    end
  end

  task automatic issue(input logic [1:0] op, input logic [7:0] a, input logic [7:0] d,
                       input logic inc, input logic push, input logic chk_data,
                       input logic [7:0] edata, input logic eerr, input int elat,
                       input int enaddr, input logic commit);
    exp_t e;
    int budget = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_data = d; cmd_inc = inc;
    while (!cmd_ready && budget < 2000) begin
      @(negedge clk);
      budget++;
    end
    if (!cmd_ready) begin
      $display("FAIL accept_timeout: got cmd_ready=0 expected 1");
      n_fail++;
    end
    e.chk_data = chk_data; e.data = edata; e.err = eerr; e.lat = elat;
    e.naddr = enaddr; e.is_commit = commit; e.acc = cyc; e.naddr0 = naddr_cnt;
    if (push) expq.push_back(e);
    $display("cmd: op=%0d addr=%02h data=%02h inc=%0b at cycle %0d", op, a, d, inc, cyc);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0; cmd_op = 2'd2; cmd_addr = 8'hEE; cmd_data = 8'hEE; cmd_inc = 1'b1;
  endtask

  task automatic drain();
    int budget = 0;
    while (expq.size() != 0 && budget < 500) begin
      @(negedge clk);
      budget++;
    end
    check("drain_queue_empty", expq.size(), 0);
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cmd_ready"}, {31'd0, cmd_ready}, 32'd1);
    check({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
    check({tag, "_rsp_data"}, {24'd0, rsp_data}, 32'd0);
    check({tag, "_rsp_err"}, {31'd0, rsp_err}, 32'd0);
    check({tag, "_mdclk"}, {31'd0, mdclk}, 32'd0);
    check({tag, "_mdopc"}, {30'd0, mdopc}, 32'd0);
    check({tag, "_mdainc"}, {31'd0, mdainc}, 32'd0);
    check({tag, "_mdwdi"}, {24'd0, mdwdi}, 32'd0);
    check({tag, "_pll_reset"}, {31'd0, pll_reset}, 32'd0);
    check({tag, "_locked"}, {31'd0, locked}, 32'd0);
  endtask

  initial begin
    int budget;
    for (int i = 0; i < 256; i++) md_mem[i] = 8'h00;
    md_mem[8'h13] = 8'h3C;
    reset_n = 1'b0;
    cmd_valid = 1'b0; cmd_op = 2'd0; cmd_addr = 8'h00; cmd_data = 8'h00; cmd_inc = 1'b0;
    cmd_valid_b = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset_n = 1'b1;

    // op, addr, data, inc, push, chk_data, edata, eerr, lat, naddr, commit
    issue(2'd0, 8'h12, 8'hA5, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 5, 1, 1'b0);
    drain();
    check("mem_12_after_write", {24'd0, md_mem[8'h12]}, 32'hA5);
    issue(2'd0, 8'h12, 8'h77, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 3, 0, 1'b0);
    issue(2'd1, 8'h13, 8'h99, 1'b0, 1'b1, 1'b1, 8'h3C, 1'b0, 4, 0, 1'b0);
    issue(2'd0, 8'hFF, 8'h11, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 5, 1, 1'b0);
    issue(2'd0, 8'h00, 8'h22, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 3, 0, 1'b0);
    drain();
    check("mem_12_inc_write", {24'd0, md_mem[8'h12]}, 32'h77);
    check("mem_00_wrapped", {24'd0, md_mem[8'h00]}, 32'h22);

    // Commit with lock arriving 5 cycles after release: 16 + 1 + 5 + 2 + 1
    issue(2'd2, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 25, 0, 1'b1);
    drain();
    check("locked_after_commit", {31'd0, locked}, 32'd1);
    issue(2'd0, 8'h40, 8'h55, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 5, 1, 1'b0);

    // Reserved opcode acts as commit; lock stuck low -> timeout at entry + 100
    lock_stuck = 1'b1;
    issue(2'd3, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 117, 0, 1'b1);
    drain();
    check("mem_40_write", {24'd0, md_mem[8'h40]}, 32'h55);

    // Async reset during the read data phase
    issue(2'd1, 8'h13, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 0, 0, 1'b0);
    budget = 0;
    while (!(mdclk && mdopc == 2'b10) && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    check("reached_read_d_hi", {31'd0, mdclk && mdopc == 2'b10}, 32'd1);
    reset_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", {31'd0, cmd_ready}, 32'd1);
    lock_stuck = 1'b0;
    issue(2'd1, 8'h13, 8'h00, 1'b0, 1'b1, 1'b1, 8'h3C, 1'b0, 6, 1, 1'b0);
    drain();

    // Tracking disabled: every access reloads the address
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      cmd_valid_b = 1'b1;
      @(negedge clk);
      cmd_valid_b = 1'b0;
      budget = 0;
      while (!rsp_valid_b && budget < 20) begin
        @(negedge clk);
        budget++;
      end
      check("notrack_rsp_seen", {31'd0, rsp_valid_b}, 32'd1);
      $display("notrack write %0d done at cycle %0d", k, cyc);
    end
    check("notrack_addr_phases", ahi_b, 2);

    check("final_queue_empty", expq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
